cdb_issue_scheduler: RTL and testbench
======================================

Name: cdb_issue_scheduler

Overview:
- Issue scheduler for the Tomasulo back end. Each cycle it decides which execution queues may issue: integer A, integer B, load/store and multiply.
- Grants are made so that no two results ever collide on the single Common Data Bus (CDB). Free CDB slots are tracked in a latency-indexed reservation shift register.
- It drives the CDB source select that the CDB mux uses to feed the ROB and the issue queues.

Parameters:
- INT_LAT, 1, cycles from integer issue to CDB broadcast.
- LS_LAT, 2, cycles from ld/st issue to CDB broadcast.
- MUL_LAT, 4, cycles from multiply issue to CDB broadcast; the multiplier is fully pipelined.
- DEPTH, MUL_LAT+1, reservation entries, indexed 0..DEPTH-1; must exceed every latency.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- flush  in  1  ROB flush flag; kills all in-flight work this cycle
- ready_int_a  in  1  integer queue A holds an issuable instruction
- ready_int_b  in  1  integer queue B holds an issuable instruction
- ready_ld_st  in  1  ld/st queue holds an issuable instruction
- ready_mul  in  1  multiply queue holds an issuable instruction
- issue_int_a  out  1  grant to queue A (combinational, same cycle)
- issue_int_b  out  1  grant to queue B
- issue_ld_st  out  1  grant to ld/st queue
- issue_mul  out  1  grant to multiply queue
- cdb_sel  out  2  unit driving the CDB this cycle: 0 int A, 1 int B, 2 ld/st, 3 mul
- cdb_sel_valid  out  1  CDB carries a valid result this cycle

Behaviour:
- State:
  - res[0..DEPTH-1]: each entry is {valid, owner[1:0]}.
  - last_int: 1 bit, the integer queue served most recently.
- Reset (async): all res entries invalid, owner 0; last_int=1, so queue A wins first. While reset is high, all issue_* = 0 and cdb_sel_valid = 0.
- CDB output:
  - cdb_sel = res[0].owner.
  - cdb_sel_valid = res[0].valid & !flush.
- Slot test: a unit with latency L may be granted only if res[L].valid = 0 and no higher-priority grant in the same cycle claims L.
- Grant priority, evaluated in this order within one cycle:
  - mul, then ld_st, then the integer pair.
  - Equal latencies across classes (parameter choice) resolve by this order.
  - Up to three grants per cycle are allowed, one per distinct latency.
- Integer pair:
  - Only one of A/B is granted per cycle.
  - If both are ready, the one with id != last_int wins.
  - If only one is ready, that one wins.
  - last_int updates to the granted id on any integer grant; otherwise it holds.
- Next state, at each posedge:
  - res[i] <= res[i+1] for i < DEPTH-1; res[DEPTH-1] <= invalid.
  - Each grant with latency L writes res[L-1] <= {1, owner}.
  - A unit granted at cycle t therefore owns the CDB at cycle t+L.
- Flush:
  - All issue_* forced to 0 in the flush cycle.
  - On the next edge every res entry is cleared. The shift is discarded, no insertions are made, and last_int holds.
  - Flush asserted on consecutive cycles keeps the register empty.
- Ready inputs are level signals. The scheduler assumes a queue deasserts ready, or presents its next entry, in the cycle after a grant; no acknowledge is needed.
- Grant without ready is illegal: issue_x implies ready_x.
- Reset mid-operation: in-flight reservations are lost; the queues are reset by the same signal.

Decomposition:
- Package cdb_sched_pkg:
  - unit id constants UNIT_INT_A=0, UNIT_INT_B=1, UNIT_LS=2, UNIT_MUL=3
  - the default latency localparams
  - a slot record typedef {valid, owner}
- Sub-module cdb_slot_ring:
  - the DEPTH-entry reservation shift register with three insertion ports (latency index + owner + enable), a clear (flush) input, and a head output.
- The top level holds the grant priority logic and last_int.

Test Plan:
1. ready_int_a held high for 6 cycles, others 0 -> issue_int_a=1 every cycle; cdb_sel=0 with cdb_sel_valid=1 from cycle 1 through cycle 6.
2. ready_int_a and ready_int_b both held high from cycle 0 -> grants alternate A,B,A,B starting with A; cdb_sel sequence 0,1,0,1 starting at cycle 1.
3. ready_mul pulsed at cycle 0, ready_int_a held high from cycle 3 -> issue_mul at cycle 0; issue_int_a=0 at cycle 3 (slot at cycle 4 taken) and 1 at cycle 4; CDB owner mul at cycle 4, int A at cycle 5.
4. ready_mul, ready_ld_st and ready_int_a all pulsed at cycle 0, register empty -> all three granted at cycle 0; cdb_sel = 0 @1, 2 @2, 3 @4; cdb_sel_valid=0 @3.
5. mul granted at cycle 0, flush=1 at cycle 2 with all ready inputs high -> no grants at cycle 2, cdb_sel_valid=0 at cycles 2, 3 and 4; normal grants resume at cycle 3.
6. ld_st granted at cycle 0, reset asserted asynchronously mid cycle 1 -> cdb_sel_valid drops immediately and stays 0 at cycle 2; after release, both int queues ready -> A granted first.

Source files
------------

// File: rtl/cdb_sched_pkg.sv
// Shared unit ids, default latencies and the CDB reservation slot record
// for the Tomasulo issue scheduler.
package cdb_sched_pkg;

  localparam int unsigned UNIT_W = 2;

  localparam logic [UNIT_W-1:0] UNIT_INT_A = 2'd0;
  localparam logic [UNIT_W-1:0] UNIT_INT_B = 2'd1;
  localparam logic [UNIT_W-1:0] UNIT_LS    = 2'd2;
  localparam logic [UNIT_W-1:0] UNIT_MUL   = 2'd3;

  localparam int unsigned INT_LAT_DEF = 1;
  localparam int unsigned LS_LAT_DEF  = 2;
  localparam int unsigned MUL_LAT_DEF = 4;

  typedef struct packed {
    logic              valid;
    logic [UNIT_W-1:0] owner;
  } slot_t;

endpackage

// File: rtl/cdb_slot_ring.sv
// Latency-indexed CDB reservation shift register: entry i describes the
// result that will occupy the CDB i cycles from now.
module cdb_slot_ring
  import cdb_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned NPORT = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [NPORT-1:0]              ins_en,
  input  logic [NPORT-1:0][IDX_W-1:0]   ins_idx,
  input  logic [NPORT-1:0][UNIT_W-1:0]  ins_owner,
  input  logic [NPORT-1:0][IDX_W-1:0]   query_idx,
  output logic [NPORT-1:0]              query_busy,
  output slot_t                         head
);

  slot_t res      [DEPTH];
  slot_t res_next [DEPTH];

  // Shift toward the head, then drop in this cycle's reservations.
  always_comb begin
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      res_next[i] = res[i+1];
    end
    res_next[DEPTH-1] = '0;
    for (int p = 0; p < int'(NPORT); p++) begin
      if (ins_en[p]) begin
        res_next[ins_idx[p]] = '{valid: 1'b1, owner: ins_owner[p]};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) res[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) res[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) res[i] <= res_next[i];
    end
  end

  always_comb begin
    query_busy = '0;
    for (int p = 0; p < int'(NPORT); p++) begin
      query_busy[p] = res[query_idx[p]].valid;
    end
  end

  assign head = res[0];

endmodule

// File: rtl/cdb_issue_scheduler.sv
// Issue scheduler: grants execution queues so that no two results ever
// collide on the single CDB, and drives the CDB source select.
module cdb_issue_scheduler
  import cdb_sched_pkg::*;
#(
  parameter int unsigned INT_LAT = INT_LAT_DEF,
  parameter int unsigned LS_LAT  = LS_LAT_DEF,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DEPTH   = MUL_LAT + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              ready_int_a,
  input  logic              ready_int_b,
  input  logic              ready_ld_st,
  input  logic              ready_mul,
  output logic              issue_int_a,
  output logic              issue_int_b,
  output logic              issue_ld_st,
  output logic              issue_mul,
  output logic [UNIT_W-1:0] cdb_sel,
  output logic              cdb_sel_valid
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          MUL_EQ_LS  = (MUL_LAT == LS_LAT);
  localparam bit          MUL_EQ_INT = (MUL_LAT == INT_LAT);
  localparam bit          LS_EQ_INT  = (LS_LAT == INT_LAT);

  // Port order on the ring: 0 mul, 1 ld/st, 2 integer pair.
  logic [2:0]              busy;
  logic [2:0]              ins_en;
  logic [2:0][IDX_W-1:0]   ins_idx;
  logic [2:0][UNIT_W-1:0]  ins_owner;
  logic [2:0][IDX_W-1:0]   query_idx;
  slot_t                   head;

  logic last_int;
  logic grant_en;
  logic pick_b;
  logic int_free;

  assign query_idx = {IDX_W'(INT_LAT), IDX_W'(LS_LAT), IDX_W'(MUL_LAT)};

  // Fixed priority mul > ld/st > integer; equal latencies lose to the earlier class.
  always_comb begin
    grant_en    = !reset && !flush;
    issue_mul   = 1'b0;
    issue_ld_st = 1'b0;
    issue_int_a = 1'b0;
    issue_int_b = 1'b0;
    int_free    = 1'b0;
    pick_b      = ready_int_b && (!ready_int_a || !last_int);

    issue_mul   = grant_en && ready_mul && !busy[0];
    issue_ld_st = grant_en && ready_ld_st && !busy[1]
                  && !(MUL_EQ_LS && issue_mul);
    int_free    = grant_en && !busy[2]
                  && !(MUL_EQ_INT && issue_mul)
                  && !(LS_EQ_INT && issue_ld_st);
    issue_int_b = int_free && pick_b;
    issue_int_a = int_free && ready_int_a && !pick_b;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_int <= 1'b1;
    end else if (issue_int_a || issue_int_b) begin
      last_int <= issue_int_b;
    end
  end

  assign ins_en    = {issue_int_a || issue_int_b, issue_ld_st, issue_mul};
  assign ins_idx   = {IDX_W'(INT_LAT - 1), IDX_W'(LS_LAT - 1), IDX_W'(MUL_LAT - 1)};
  assign ins_owner = {(issue_int_b ? UNIT_INT_B : UNIT_INT_A), UNIT_LS, UNIT_MUL};

  cdb_slot_ring #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .NPORT (3)
  ) u_ring (
    .clock      (clock),
    .reset      (reset),
    .clear      (flush),
    .ins_en     (ins_en),
    .ins_idx    (ins_idx),
    .ins_owner  (ins_owner),
    .query_idx  (query_idx),
    .query_busy (busy),
    .head       (head)
  );

  assign cdb_sel       = head.owner;
  assign cdb_sel_valid = head.valid && !flush;

endmodule

// File: tb/tb_cdb_issue_scheduler.sv
// Directed self-checking bench for cdb_issue_scheduler with hand-computed
// grant and CDB-select expectations.
module tb_cdb_issue_scheduler;

  logic       clock;
  logic       reset;
  logic       flush;
  logic       ready_int_a;
  logic       ready_int_b;
  logic       ready_ld_st;
  logic       ready_mul;
  logic       issue_int_a;
  logic       issue_int_b;
  logic       issue_ld_st;
  logic       issue_mul;
  logic [1:0] cdb_sel;
  logic       cdb_sel_valid;

  int tests_run;
  int tests_failed;

  cdb_issue_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .ready_int_a   (ready_int_a),
    .ready_int_b   (ready_int_b),
    .ready_ld_st   (ready_ld_st),
    .ready_mul     (ready_mul),
    .issue_int_a   (issue_int_a),
    .issue_int_b   (issue_int_b),
    .issue_ld_st   (issue_ld_st),
    .issue_mul     (issue_mul),
    .cdb_sel       (cdb_sel),
    .cdb_sel_valid (cdb_sel_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ei = {mul, ld_st, int_b, int_a}; cdb_sel only compared when a result is expected.
  task automatic chk_cyc(input string tag, input logic [3:0] ei, input logic ev,
                         input logic [1:0] es);
    chk({tag, "_iss"}, {issue_mul, issue_ld_st, issue_int_b, issue_int_a}, ei);
    chk({tag, "_vld"}, {3'b000, cdb_sel_valid}, {3'b000, ev});
    if (ev) chk({tag, "_sel"}, {2'b00, cdb_sel}, {2'b00, es});
  endtask

  task automatic clear_inputs();
    flush       = 1'b0;
    ready_int_a = 1'b0;
    ready_int_b = 1'b0;
    ready_ld_st = 1'b0;
    ready_mul   = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear_inputs();
    reset = 1'b1;

    // Reset state: grants suppressed even with every queue ready.
    #2;
    ready_int_a = 1'b1; ready_int_b = 1'b1; ready_ld_st = 1'b1; ready_mul = 1'b1;
    #1;
    chk_cyc("rst", 4'b0000, 1'b0, 2'd0);

    // 1: A alone, back-to-back grants, CDB owned by A from cycle 1.
    do_reset();
    ready_int_a = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      chk_cyc($sformatf("t1_c%0d", c), 4'b0001, (c > 0), 2'd0);
      next_cycle();
    end
    ready_int_a = 1'b0;
    @(negedge clock);
    chk_cyc("t1_c6", 4'b0000, 1'b1, 2'd0);
    next_cycle();
    @(negedge clock);
    chk_cyc("t1_c7", 4'b0000, 1'b0, 2'd0);

    // 2: A and B both ready, alternate starting with A.
    do_reset();
    ready_int_a = 1'b1; ready_int_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk_cyc($sformatf("t2_c%0d", c), (c % 2 == 0) ? 4'b0001 : 4'b0010,
              (c > 0), ((c - 1) % 2 == 0) ? 2'd0 : 2'd1);
      next_cycle();
    end

    // 3: mul at 0 blocks the int slot at cycle 4.
    do_reset();
    ready_mul = 1'b1;
    @(negedge clock); chk_cyc("t3_c0", 4'b1000, 1'b0, 2'd0);
    next_cycle(); ready_mul = 1'b0;
    @(negedge clock); chk_cyc("t3_c1", 4'b0000, 1'b0, 2'd0);
    next_cycle();
    @(negedge clock); chk_cyc("t3_c2", 4'b0000, 1'b0, 2'd0);
    next_cycle(); ready_int_a = 1'b1;
    @(negedge clock); chk_cyc("t3_c3", 4'b0000, 1'b0, 2'd0);
    next_cycle();
    @(negedge clock); chk_cyc("t3_c4", 4'b0001, 1'b1, 2'd3);
    next_cycle(); ready_int_a = 1'b0;
    @(negedge clock); chk_cyc("t3_c5", 4'b0000, 1'b1, 2'd0);

    // 4: three distinct latencies granted together.
    do_reset();
    ready_mul = 1'b1; ready_ld_st = 1'b1; ready_int_a = 1'b1;
    @(negedge clock); chk_cyc("t4_c0", 4'b1101, 1'b0, 2'd0);
    next_cycle(); clear_inputs();
    @(negedge clock); chk_cyc("t4_c1", 4'b0000, 1'b1, 2'd0);
    next_cycle();
    @(negedge clock); chk_cyc("t4_c2", 4'b0000, 1'b1, 2'd2);
    next_cycle();
    @(negedge clock); chk_cyc("t4_c3", 4'b0000, 1'b0, 2'd0);
    next_cycle();
    @(negedge clock); chk_cyc("t4_c4", 4'b0000, 1'b1, 2'd3);
    next_cycle();
    @(negedge clock); chk_cyc("t4_c5", 4'b0000, 1'b0, 2'd0);

    // 5: flush kills the mul reservation and masks a live CDB head.
    do_reset();
    ready_mul = 1'b1;
    @(negedge clock); chk_cyc("t5_c0", 4'b1000, 1'b0, 2'd0);
    next_cycle(); ready_mul = 1'b0;
    @(negedge clock); chk_cyc("t5_c1", 4'b0000, 1'b0, 2'd0);
    next_cycle();
    flush = 1'b1; ready_int_a = 1'b1; ready_int_b = 1'b1; ready_ld_st = 1'b1; ready_mul = 1'b1;
    @(negedge clock); chk_cyc("t5_c2", 4'b0000, 1'b0, 2'd0);
    next_cycle();
    flush = 1'b0; ready_int_a = 1'b0; ready_int_b = 1'b0;
    @(negedge clock); chk_cyc("t5_c3", 4'b1100, 1'b0, 2'd0);
    next_cycle(); clear_inputs();
    @(negedge clock); chk_cyc("t5_c4", 4'b0000, 1'b0, 2'd0);
    next_cycle();
    @(negedge clock); chk_cyc("t5_c5", 4'b0000, 1'b1, 2'd2);
    flush = 1'b1;
    #1;
    chk_cyc("t5_c5f", 4'b0000, 1'b0, 2'd0);
    next_cycle();
    @(negedge clock); chk_cyc("t5_c6", 4'b0000, 1'b0, 2'd0);
    next_cycle();
    flush = 1'b0; ready_int_a = 1'b1; ready_int_b = 1'b1;
    @(negedge clock); chk_cyc("t5_c7", 4'b0001, 1'b0, 2'd0);
    next_cycle(); clear_inputs();
    @(negedge clock); chk_cyc("t5_c8", 4'b0000, 1'b1, 2'd0);

    // 6: async reset mid-cycle drops the ld/st reservation; A wins after release.
    do_reset();
    ready_ld_st = 1'b1;
    @(negedge clock); chk_cyc("t6_c0", 4'b0100, 1'b0, 2'd0);
    next_cycle(); ready_ld_st = 1'b0;
    #1;
    reset = 1'b1; ready_int_a = 1'b1; ready_int_b = 1'b1;
    #1;
    chk_cyc("t6_c1r", 4'b0000, 1'b0, 2'd0);
    next_cycle();
    @(negedge clock); chk_cyc("t6_c2r", 4'b0000, 1'b0, 2'd0);
    reset = 1'b0;
    #1;
    chk_cyc("t6_c2", 4'b0001, 1'b0, 2'd0);
    next_cycle();
    @(negedge clock); chk_cyc("t6_c3", 4'b0010, 1'b1, 2'd0);
    next_cycle(); clear_inputs();
    @(negedge clock); chk_cyc("t6_c4", 4'b0000, 1'b1, 2'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
